// File: rtl/wishbus_copy_dma.sv
// wishbus_copy_dma: word-copy bus master for one wishbus arbiter slot.
// Each 16-bit word is moved with one read access followed by one write
// access. The bus is requested before and released after every access, so
// the arbiter always gets a chance to regrant between accesses.
// Every output comes from a flop. Each output's next value is derived from
// the next state, so the output lines up with the state it describes.
module wishbus_copy_dma #(
    parameter int LEN_W   = 10,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      src_i,
    input  logic [31:0]      dst_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] count_o,
    output logic             bus_sel_o,
    input  logic             bus_ack_i,
    output logic             bus_stb_o,
    output logic             bus_we_o,
    output logic [31:0]      bus_addr_o,
    output logic [15:0]      bus_dat_o,
    input  logic [15:0]      bus_dat_i,
    input  logic             bus_cyc_i
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD_REQ  = 4'd1,
        S_RD_STB  = 4'd2,
        S_RD_WAIT = 4'd3,
        S_RD_GAP  = 4'd4,
        S_WR_REQ  = 4'd5,
        S_WR_STB  = 4'd6,
        S_WR_WAIT = 4'd7,
        S_WR_GAP  = 4'd8,
        S_DONE    = 4'd9
    } state_e;

    // The timer counts cycles already spent in the current state. The state
    // gives up on the cycle where the timer holds TIMEOUT-1, which is its
    // TIMEOUT-th cycle.
    localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [31:0]      ADDR_MSK = 32'hFFFF_FFFE;

    state_e             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [15:0]        data_q, data_d;
    logic               seen_q, seen_d;
    logic               abort_q, abort_d;
    logic               err_q, err_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               zero_done_s;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sel_q, sel_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [15:0]        dat_q, dat_d;
    logic               rd_phase_s, wr_phase_s, bus_held_s;

    // Next-state, datapath and status update for the copy sequencer.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        count_d     = count_q;
        data_d      = data_q;
        seen_d      = seen_q;
        err_d       = err_q;
        zero_done_s = 1'b0;

        // Abort only ever stops the engine at an access boundary.
        if (state_q == S_IDLE) begin
            abort_d = 1'b0;
        end else begin
            abort_d = abort_q | abort_i;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i && (len_i != '0)) begin
                    src_d   = src_i & ADDR_MSK;
                    dst_d   = dst_i & ADDR_MSK;
                    len_d   = len_i;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = S_RD_REQ;
                end else if (start_i) begin
                    zero_done_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_REQ, S_WR_REQ: begin
                if (bus_ack_i) begin
                    state_d = (state_q == S_RD_REQ) ? S_RD_STB : S_WR_STB;
                end else if (timer_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = state_q;
                end
            end
            S_RD_STB: begin
                state_d = S_RD_WAIT;
            end
            S_WR_STB: begin
                state_d = S_WR_WAIT;
            end
            S_RD_WAIT, S_WR_WAIT: begin
                if (seen_q && !bus_cyc_i) begin
                    if (state_q == S_RD_WAIT) begin
                        data_d  = bus_dat_i;
                        state_d = S_RD_GAP;
                    end else begin
                        count_d = count_q + LEN_W'(1);
                        src_d   = src_q + 32'd2;
                        dst_d   = dst_q + 32'd2;
                        state_d = S_WR_GAP;
                    end
                end else if (timer_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    seen_d  = seen_q | bus_cyc_i;
                end
            end
            S_RD_GAP: begin
                // An abort here finishes without writing the word just read.
                if (abort_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WR_REQ;
                end
            end
            S_WR_GAP: begin
                if ((count_q == len_q) || abort_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The seen flag and the timer both restart whenever the state changes.
        if (state_d != state_q) begin
            seen_d  = 1'b0;
            timer_d = '0;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    // Next output values, derived from the state being entered.
    always_comb begin
        rd_phase_s = (state_d == S_RD_REQ) || (state_d == S_RD_STB) ||
                     (state_d == S_RD_WAIT) || (state_d == S_RD_GAP);
        wr_phase_s = (state_d == S_WR_REQ) || (state_d == S_WR_STB) ||
                     (state_d == S_WR_WAIT) || (state_d == S_WR_GAP);
        bus_held_s = (state_d == S_RD_REQ) || (state_d == S_RD_STB) ||
                     (state_d == S_RD_WAIT) || (state_d == S_WR_REQ) ||
                     (state_d == S_WR_STB) || (state_d == S_WR_WAIT);
        sel_d  = ~bus_held_s;
        stb_d  = (state_d == S_RD_STB) || (state_d == S_WR_STB);
        we_d   = ~wr_phase_s;
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE) || zero_done_s;
        if (rd_phase_s) begin
            addr_d = src_d;
        end else if (wr_phase_s) begin
            addr_d = dst_d;
        end else begin
            addr_d = 32'd0;
        end
        if (wr_phase_s) begin
            dat_d = data_d;
        end else begin
            dat_d = 16'd0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            src_q   <= 32'd0;
            dst_q   <= 32'd0;
            len_q   <= '0;
            count_q <= '0;
            data_q  <= 16'd0;
            seen_q  <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= 1'b1;
            stb_q   <= 1'b0;
            we_q    <= 1'b1;
            addr_q  <= 32'd0;
            dat_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            count_q <= count_d;
            data_q  <= data_d;
            seen_q  <= seen_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign count_o    = count_q;
    assign bus_sel_o  = sel_q;
    assign bus_stb_o  = stb_q;
    assign bus_we_o   = we_q;
    assign bus_addr_o = addr_q;
    assign bus_dat_o  = dat_q;

endmodule

// File: tb/tb_wishbus_copy_dma.sv
// Self-checking bench for wishbus_copy_dma.
// The bench models an arbiter that grants after a fixed or random delay and
// a 16-bit RAM whose cycle-active line stays high for 3 cycles.
// A word-level copy model predicts the RAM contents and the sequence of
// bus addresses.
module tb_wishbus_copy_dma;
    localparam int LEN_W   = 10;
    localparam int TIMEOUT = 255;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             start_i = 1'b0;
    logic [31:0]      src_i = 32'd0;
    logic [31:0]      dst_i = 32'd0;
    logic [LEN_W-1:0] len_i = '0;
    logic             abort_i = 1'b0;
    logic             busy_o, done_o, err_o;
    logic [LEN_W-1:0] count_o;
    logic             bus_sel_o, bus_stb_o, bus_we_o;
    logic             bus_ack_i = 1'b0;
    logic             bus_cyc_i = 1'b0;
    logic [31:0]      bus_addr_o;
    logic [15:0]      bus_dat_o;
    logic [15:0]      bus_dat_i = 16'd0;

    wishbus_copy_dma #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .src_i(src_i),
        .dst_i(dst_i), .len_i(len_i), .abort_i(abort_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .count_o(count_o),
        .bus_sel_o(bus_sel_o), .bus_ack_i(bus_ack_i), .bus_stb_o(bus_stb_o),
        .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_dat_o(bus_dat_o),
        .bus_dat_i(bus_dat_i), .bus_cyc_i(bus_cyc_i)
    );

    initial forever #5 clk = ~clk;

    logic [15:0] mem     [0:4095];
    logic [15:0] ref_mem [0:4095];
    logic [31:0] rd_q[$], wa_q[$], exp_rd[$], exp_wa[$];
    logic [15:0] wd_q[$], exp_wd[$];
    int done_cnt, busy_cnt, sel_low_cnt, gap_viol, n_access;
    int cyc_left, req_cnt, need;
    bit granted, sel_high_seen, dead, contention;
    int n_checks, n_errors;

    function automatic int widx(input logic [31:0] a);
        return int'(a[12:1]);
    endfunction

    // Word-level reference: each word is read then written, in order.
    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] a, b;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        for (int i = 0; i < n; i++) begin
            a = (s & 32'hFFFF_FFFE) + 32'(2 * i);
            b = (d & 32'hFFFF_FFFE) + 32'(2 * i);
            exp_rd.push_back(a);
            exp_wa.push_back(b);
            exp_wd.push_back(ref_mem[widx(a)]);
            ref_mem[widx(b)] = ref_mem[widx(a)];
        end
    endtask

    function automatic int mem_diff();
        int e = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) e++;
        return e;
    endfunction

    function automatic int log_diff();
        int e = 0;
        if (rd_q.size() != exp_rd.size()) e++;
        else for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] !== exp_rd[i]) e++;
        if (wa_q.size() != exp_wa.size()) e++;
        else for (int i = 0; i < wa_q.size(); i++)
            if ((wa_q[i] !== exp_wa[i]) || (wd_q[i] !== exp_wd[i])) e++;
        return e;
    endfunction

    // Arbiter and RAM responder, acting on the falling edge.
    initial begin
        need = 2; req_cnt = 0; granted = 0; cyc_left = 0; sel_high_seen = 1;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                bus_ack_i = 1'b0; bus_cyc_i = 1'b0; cyc_left = 0;
                req_cnt = 0; granted = 0; sel_high_seen = 1;
            end else begin
                if (bus_ack_i) bus_ack_i = 1'b0;
                if (!bus_sel_o) begin
                    sel_low_cnt++;
                    if (!granted) begin
                        req_cnt++;
                        if (req_cnt >= need) begin bus_ack_i = 1'b1; granted = 1; end
                    end
                end else begin
                    granted = 0; req_cnt = 0; sel_high_seen = 1;
                    need = contention ? int'($urandom_range(2, 7)) : 2;
                end
                if (cyc_left > 0) begin
                    cyc_left--;
                    if (cyc_left == 0) bus_cyc_i = 1'b0;
                end
                if (bus_stb_o) begin
                    if (!sel_high_seen && n_access > 0) gap_viol++;
                    sel_high_seen = 0;
                    n_access++;
                    if (!dead) begin bus_cyc_i = 1'b1; cyc_left = 3; end
                    if (bus_we_o) begin
                        rd_q.push_back(bus_addr_o);
                        bus_dat_i = mem[widx(bus_addr_o)];
                    end else begin
                        wa_q.push_back(bus_addr_o);
                        wd_q.push_back(bus_dat_o);
                        mem[widx(bus_addr_o)] = bus_dat_o;
                    end
                end
                if (done_o) done_cnt++;
                if (busy_o) busy_cnt++;
            end
        end
    end

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] n);
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        done_cnt = 0; busy_cnt = 0; sel_low_cnt = 0; gap_viol = 0; n_access = 0;
        @(negedge clk);
        start_i = 1'b1; src_i = s; dst_i = d; len_i = n;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit timed_out, output int lat);
        timed_out = 1; lat = -1;
        for (int i = 0; i < bound; i++) begin
            if (done_o) begin timed_out = 0; lat = i; break; end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy_o, done_o, err_o, bus_stb_o, bus_sel_o, bus_we_o} !== 6'b000011) begin
            n_errors++;
            $display("FAIL reset_ctrl got %b want 000011",
                     {busy_o, done_o, err_o, bus_stb_o, bus_sel_o, bus_we_o});
        end
        n_checks++;
        if ({count_o, bus_addr_o, bus_dat_o} !== {10'd0, 32'd0, 16'd0}) begin
            n_errors++;
            $display("FAIL reset_data count=%0d addr=%h dat=%h want 0/0/0", count_o, bus_addr_o, bus_dat_o);
        end
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit to; int lat;
        mem[widx(32'h10)] = 16'hBEEF; ref_mem[widx(32'h10)] = 16'hBEEF;
        model_copy(32'h10, 32'h40, 1);
        start_copy(32'h10, 32'h40, 10'd1);
        wait_done(100, to, lat);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL single_done no done pulse within 100 cycles, want one"); end
        n_checks++;
        if (mem[widx(32'h40)] !== 16'hBEEF) begin n_errors++; $display("FAIL single_data got %h want beef", mem[widx(32'h40)]); end
        n_checks++;
        if (log_diff() != 0) begin n_errors++; $display("FAIL single_bus %0d address/data differences, want 0", log_diff()); end
        n_checks++;
        if ({count_o, err_o} !== {10'd1, 1'b0}) begin n_errors++; $display("FAIL single_status count=%0d err=%b want 1/0", count_o, err_o); end
        n_checks++;
        if (done_cnt != 1) begin n_errors++; $display("FAIL single_pulses got %0d done cycles want 1", done_cnt); end
    endtask

    task automatic test_contention();
        bit to; int lat;
        contention = 1;
        model_copy(32'h100, 32'h200, 4);
        start_copy(32'h100, 32'h200, 10'd4);
        wait_done(300, to, lat);
        contention = 0;
        n_checks++;
        if (to || mem_diff() != 0 || log_diff() != 0) begin
            n_errors++;
            $display("FAIL contention_copy timeout=%0d memdiff=%0d busdiff=%0d want 0/0/0", to, mem_diff(), log_diff());
        end
        n_checks++;
        if (gap_viol != 0) begin n_errors++; $display("FAIL contention_gap got %0d accesses without release want 0", gap_viol); end
        n_checks++;
        if (count_o !== 10'd4) begin n_errors++; $display("FAIL contention_count got %0d want 4", count_o); end
    endtask

    task automatic test_random();
        bit to; int lat; logic [31:0] s, d; logic [LEN_W-1:0] n;
        for (int it = 0; it < 6; it++) begin
            contention = bit'($urandom_range(0, 1));
            s = 32'($urandom_range(0, 8191));
            d = 32'($urandom_range(0, 8191));
            n = LEN_W'($urandom_range(1, 6));
            model_copy(s, d, int'(n));
            start_copy(s, d, n);
            wait_done(40 * int'(n) + 40, to, lat);
            n_checks++;
            if (to || mem_diff() != 0 || log_diff() != 0 || count_o !== n || gap_viol != 0) begin
                n_errors++;
                $display("FAIL random_copy%0d src=%h dst=%h len=%0d timeout=%0d memdiff=%0d busdiff=%0d count=%0d gaps=%0d want 0/0/0/%0d/0",
                         it, s, d, n, to, mem_diff(), log_diff(), count_o, gap_viol, n);
            end
        end
        contention = 0;
    endtask

    task automatic test_wrap();
        bit to; int lat;
        model_copy(32'hFFFF_FFFC, 32'h0000_0FFE, 3);
        start_copy(32'hFFFF_FFFC, 32'h0000_0FFE, 10'd3);
        wait_done(200, to, lat);
        n_checks++;
        if (to || mem_diff() != 0 || log_diff() != 0) begin
            n_errors++;
            $display("FAIL wrap_copy timeout=%0d memdiff=%0d busdiff=%0d want 0/0/0", to, mem_diff(), log_diff());
        end
    endtask

    task automatic test_zero_len();
        bit to; int lat;
        start_copy(32'h20, 32'h60, 10'd0);
        wait_done(10, to, lat);
        repeat (4) @(negedge clk);
        n_checks++;
        if (to || lat != 0) begin n_errors++; $display("FAIL zero_latency got %0d cycles want 0 after start sampled", lat); end
        n_checks++;
        if (done_cnt != 1 || busy_cnt != 0 || sel_low_cnt != 0) begin
            n_errors++;
            $display("FAIL zero_quiet done=%0d busy=%0d sel_low=%0d want 1/0/0", done_cnt, busy_cnt, sel_low_cnt);
        end
    endtask

    task automatic test_abort();
        bit to, seen3; int lat;
        model_copy(32'h500, 32'h900, 2);
        exp_rd.push_back(32'h504);
        start_copy(32'h500, 32'h900, 10'd8);
        seen3 = 0;
        for (int i = 0; i < 200; i++) begin
            if (rd_q.size() >= 3) begin seen3 = 1; break; end
            @(negedge clk);
        end
        @(negedge clk); abort_i = 1'b1;
        @(negedge clk); abort_i = 1'b0;
        wait_done(200, to, lat);
        n_checks++;
        if (!seen3 || to) begin n_errors++; $display("FAIL abort_progress third_read=%0d done_timeout=%0d want 1/0", seen3, to); end
        n_checks++;
        if (count_o !== 10'd2 || log_diff() != 0 || mem_diff() != 0) begin
            n_errors++;
            $display("FAIL abort_result count=%0d busdiff=%0d memdiff=%0d want 2/0/0", count_o, log_diff(), mem_diff());
        end
        n_checks++;
        if (done_cnt != 1 || err_o !== 1'b0) begin n_errors++; $display("FAIL abort_status done=%0d err=%b want 1/0", done_cnt, err_o); end
    endtask

    task automatic test_timeout();
        bit to, got_stb; int lat, k;
        dead = 1;
        start_copy(32'h300, 32'h700, 10'd4);
        got_stb = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus_stb_o) begin got_stb = 1; break; end
            @(negedge clk);
        end
        k = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            k = i;
            if (err_o) break;
        end
        n_checks++;
        if (!got_stb || k != TIMEOUT + 1) begin
            n_errors++;
            $display("FAIL timeout_latency err after %0d cycles from strobe want %0d", k, TIMEOUT + 1);
        end
        n_checks++;
        if ({done_o, bus_sel_o, bus_stb_o, busy_o} !== 4'b1100) begin
            n_errors++;
            $display("FAIL timeout_release done/sel/stb/busy=%b want 1100", {done_o, bus_sel_o, bus_stb_o, busy_o});
        end
        repeat (3) @(negedge clk);
        dead = 0;
        n_checks++;
        if (err_o !== 1'b1 || count_o !== 10'd0) begin n_errors++; $display("FAIL timeout_sticky err=%b count=%0d want 1/0", err_o, count_o); end
        model_copy(32'h300, 32'h700, 2);
        start_copy(32'h300, 32'h700, 10'd2);
        n_checks++;
        if (err_o !== 1'b0) begin n_errors++; $display("FAIL timeout_clear err=%b want 0 after new start", err_o); end
        wait_done(200, to, lat);
        n_checks++;
        if (to || mem_diff() != 0 || log_diff() != 0 || err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_recover timeout=%0d memdiff=%0d busdiff=%0d err=%b want 0/0/0/0", to, mem_diff(), log_diff(), err_o);
        end
    endtask

    task automatic test_reset_mid();
        bit to, got_wr; int lat;
        model_copy(32'hA00, 32'hB00, 1);
        start_copy(32'hA00, 32'hB00, 10'd3);
        got_wr = 0;
        for (int i = 0; i < 200; i++) begin
            if (wa_q.size() >= 1) begin got_wr = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (!got_wr || {busy_o, done_o, err_o, bus_stb_o, bus_sel_o, bus_we_o} !== 6'b000011 ||
            count_o !== 10'd0 || bus_addr_o !== 32'd0 || bus_dat_o !== 16'd0) begin
            n_errors++;
            $display("FAIL midreset_outputs write_seen=%0d ctrl=%b count=%0d addr=%h dat=%h want 1/000011/0/0/0",
                     got_wr, {busy_o, done_o, err_o, bus_stb_o, bus_sel_o, bus_we_o}, count_o, bus_addr_o, bus_dat_o);
        end
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_diff() != 0) begin n_errors++; $display("FAIL midreset_partial memdiff=%0d want 0", mem_diff()); end
        model_copy(32'hC10, 32'hD20, 3);
        start_copy(32'hC10, 32'hD20, 10'd3);
        wait_done(200, to, lat);
        n_checks++;
        if (to || mem_diff() != 0 || log_diff() != 0 || count_o !== 10'd3) begin
            n_errors++;
            $display("FAIL midreset_clean timeout=%0d memdiff=%0d busdiff=%0d count=%0d want 0/0/0/3", to, mem_diff(), log_diff(), count_o);
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; dead = 0; contention = 0;
        done_cnt = 0; busy_cnt = 0; sel_low_cnt = 0; gap_viol = 0; n_access = 0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_single();
        test_contention();
        test_random();
        test_wrap();
        test_zero_len();
        test_abort();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/wishbus_copy_dma.md
# wishbus_copy_dma

Word-copy engine acting as a bus master on one user slot of the four-way wishbus arbiter. On a start command it moves `len_i` 16-bit words from a source byte address to a destination byte address, one read then one write per word, requesting and releasing the bus for every access. It sits directly upstream of the arbiter; the arbiter in turn feeds the RAM-to-wishbus adapter. Completion and error are reported to the controlling logic.

## Interface

**Parameters**

- `LEN_W`, default 10: width of the length and progress counters (max 2^LEN_W-1 words).
- `TIMEOUT`, default 255: max cycles waited in any request or wait state before aborting with error.

**Ports**

- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: command strobe, sampled only in IDLE.
- `src_i` in 32: source byte address, bit 0 ignored.
- `dst_i` in 32: destination byte address, bit 0 ignored.
- `len_i` in LEN_W: word count; 0 = no-op.
- `abort_i` in 1: stop after the current bus access completes.
- `busy_o` out 1: high from accepted start until DONE.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: sticky timeout flag; cleared by next accepted start.
- `count_o` out LEN_W: words fully written.
- `bus_sel_o` out 1: active-low bus request to arbiter.
- `bus_ack_i` in 1: one-cycle grant pulse from arbiter.
- `bus_stb_o` out 1: access strobe toward device.
- `bus_we_o` out 1: 1 = read, 0 = write (bus convention).
- `bus_addr_o` out 32: byte address.
- `bus_dat_o` out 16: write data.
- `bus_dat_i` in 16: read data from device.
- `bus_cyc_i` in 1: device cycle-active indicator.

## Operation

**Reset values**

- Outputs: `bus_sel_o`=1, `bus_we_o`=1; all other outputs 0.
- Internal: data latch 0, state IDLE.

**States**

- **IDLE**
  - `start_i` with `len_i`≠0: latch src/dst/len, clear `count_o`/`err_o`, go to RD_REQ.
  - `start_i` with `len_i`=0: pulse `done_o` next cycle, stay IDLE, `busy_o` stays 0.
- **RD_REQ / WR_REQ**
  - `bus_sel_o`=0, address and `bus_we_o` stable.
  - `bus_ack_i`=1 → go to RD_STB / WR_STB.
- **RD_STB / WR_STB**
  - `bus_stb_o`=1 for exactly one cycle; go to RD_WAIT / WR_WAIT.
- **RD_WAIT / WR_WAIT**
  - Keep `bus_sel_o`=0 and the address stable.
  - Set a seen flag when `bus_cyc_i`=1.
  - Access completes on the first cycle with seen=1 and `bus_cyc_i`=0.
  - Read completion: latch `bus_dat_i`, go to RD_GAP.
  - Write completion: increment `count_o`, advance src and dst by 2, go to WR_GAP.
- **RD_GAP / WR_GAP**
  - `bus_sel_o`=1 for one cycle so the arbiter can regrant.
  - RD_GAP → WR_REQ.
  - WR_GAP → DONE if `count_o`==len or abort is pending; otherwise RD_REQ.
- **DONE**
  - One cycle: `done_o`=1, `busy_o` drops; go to IDLE.

**Rules**

- `bus_addr_o` = src in read states, dst in write states.
- `bus_dat_o` = latched data in write states, 0 otherwise.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- `abort_i` sets a pending flag in any non-IDLE state.
  - Checked only in WR_GAP, and in RD_GAP where it goes to DONE without writing.
  - A word is never half-copied into `count_o`.
- Timeout counter resets on every state change.
  - Reaching TIMEOUT in REQ or WAIT: `err_o`=1, release bus (`bus_sel_o`=1, `bus_stb_o`=0), go to DONE.
- `start_i` outside IDLE is ignored.
- Asynchronous reset mid-transfer returns everything to reset values immediately, with no bus release sequence beyond `bus_sel_o`=1.

## Timing

**Per word with ideal arbiter and device**

- REQ→ack: 2 cycles.
- STB: 1 cycle.
- RAM access: cyc high for 3 cycles, falls 1 cycle later.
- GAP: 1 cycle.
- Total ≈ 8 cycles per access, 16 per word.

**Outputs**

- `done_o` is asserted 1 cycle after the final WR_GAP.
- `count_o` updates in the cycle after write completion.
- All outputs are registered; there is no combinational path from bus inputs to bus outputs.

## Test plan

- **Single-word copy:** RAM model preloaded [0x0010]=0xBEEF; start src=0x10, dst=0x40, len=1 → one read at 0x10, then one write of 0xBEEF at 0x40, `count_o`=1, single `done_o` pulse, `err_o`=0.
- **Multi-word copy with contention:** len=4, src=0x100, dst=0x200; arbiter also serves another user on a higher-priority slot → words at 0x200..0x206 equal the source, `bus_sel_o` high for ≥1 cycle between every access.
- **Zero-length command:** len=0 → `done_o` pulse 1 cycle later, no `bus_sel_o` low, `busy_o` never high.
- **Abort mid-read:** len=8, `abort_i` pulsed during the 3rd word's RD_WAIT → read completes, no write occurs, `count_o`=2, `done_o` pulsed.
- **Timeout:** device never raises `bus_cyc_i`, TIMEOUT=255 → `err_o`=1 after 255 WAIT cycles, bus released, `done_o` pulsed; the next start clears `err_o`.
- **Reset mid-transfer:** `rst_ni` low during WR_WAIT → all outputs at reset values immediately; start after release performs a clean copy.
